// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU and condition functions,
// one-hot status codes, register IDs and the E->M pipeline register layout.
package y86_pkg;

    localparam int WORD = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] SAOK = 4'b1000;
    localparam logic [3:0] SHLT = 4'b0100;
    localparam logic [3:0] SADR = 4'b0010;
    localparam logic [3:0] SINS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic            cnd;
        logic [WORD-1:0] val_e;
        logic [WORD-1:0] val_a;
        logic [3:0]      dst_e;
        logic [3:0]      dst_m;
    } mreg_t;

    // Reset and bubble share the same image: an AOK nop writing nothing.
    localparam mreg_t MREG_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        cnd:   1'b0,
        val_e: 64'd0,
        val_a: 64'd0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic lt;
        lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   cond_eval = 1'b1;
            C_LE:    cond_eval = lt | cc.zf;
            C_L:     cond_eval = lt;
            C_E:     cond_eval = cc.zf;
            C_NE:    cond_eval = ~cc.zf;
            C_GE:    cond_eval = ~lt;
            C_G:     cond_eval = ~lt & ~cc.zf;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result of B op A plus zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
(
    input  logic [WORD-1:0] alu_a,
    input  logic [WORD-1:0] alu_b,
    input  logic [3:0]      alu_fn,
    output logic [WORD-1:0] res,
    output logic            zf,
    output logic            sf,
    output logic            of
);

    always_comb begin
        case (alu_fn)
            ALUADD:  res = alu_b + alu_a;
            ALUSUB:  res = alu_b - alu_a;
            ALUAND:  res = alu_b & alu_a;
            ALUXOR:  res = alu_b ^ alu_a;
            default: res = '0;
        endcase
    end

    // Overflow is judged from operand and result sign bits only.
    always_comb begin
        case (alu_fn)
            ALUADD:  of = (alu_a[WORD-1] == alu_b[WORD-1]) && (res[WORD-1] != alu_a[WORD-1]);
            ALUSUB:  of = (alu_a[WORD-1] != alu_b[WORD-1]) && (res[WORD-1] != alu_b[WORD-1]);
            default: of = 1'b0;
        endcase
        zf = (res == '0);
        sf = res[WORD-1];
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: ALU operand selection, condition codes, cmov/jump
// condition, forwarding outputs to decode and the E->M pipeline register.
module execute_stage
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valc,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  m_stat,
    input  logic [3:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic [3:0]  M_ifun,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  CC
);

    localparam logic [WORD-1:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [WORD-1:0] STACK_INC = 64'd8;

    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [3:0]      alu_fn;
    logic [WORD-1:0] alu_res;
    logic            alu_zf;
    logic            alu_sf;
    logic            alu_of;
    logic            set_cc;
    cc_t             cc_q;
    cc_t             cc_d;
    mreg_t           mreg_q;
    mreg_t           mreg_d;

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (E_icode)
            IRRMOVQ: alu_a = E_valA;
            IIRMOVQ: alu_a = E_valc;
            IRMMOVQ, IMRMOVQ: begin
                alu_a = E_valc;
                alu_b = E_valB;
            end
            IOPQ: begin
                alu_a = E_valA;
                alu_b = E_valB;
            end
            ICALL, IPUSHQ: begin
                alu_a = STACK_DEC;
                alu_b = E_valB;
            end
            IRET, IPOPQ: begin
                alu_a = STACK_INC;
                alu_b = E_valB;
            end
            default: ;
        endcase
        alu_fn = (E_icode == IOPQ) ? E_ifun : ALUADD;
    end

    y86_alu u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .res    (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Only downstream exceptions block CC; the E instruction's own stat does not.
    always_comb begin
        set_cc = (E_icode == IOPQ) && (m_stat == SAOK) && (W_stat == SAOK);
        cc_d   = cc_q;
        if (set_cc) begin
            cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
        end
    end

    always_comb begin
        e_valE = alu_res;
        e_Cnd  = ((E_icode == IRRMOVQ) || (E_icode == IJXX)) ? cond_eval(E_ifun, cc_q) : 1'b0;
        e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE : E_dstE;
    end

    always_comb begin
        mreg_d = MREG_BUBBLE;
        if (!M_bubble) begin
            mreg_d.stat  = E_stat;
            mreg_d.icode = E_icode;
            mreg_d.ifun  = E_ifun;
            mreg_d.cnd   = e_Cnd;
            mreg_d.val_e = e_valE;
            mreg_d.val_a = E_valA;
            mreg_d.dst_e = e_dstE;
            mreg_d.dst_m = E_dstM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q   <= CC_RESET;
            mreg_q <= MREG_BUBBLE;
        end else begin
            cc_q   <= cc_d;
            mreg_q <= mreg_d;
        end
    end

    assign M_stat  = mreg_q.stat;
    assign M_icode = mreg_q.icode;
    assign M_ifun  = mreg_q.ifun;
    assign M_Cnd   = mreg_q.cnd;
    assign M_valE  = mreg_q.val_e;
    assign M_valA  = mreg_q.val_a;
    assign M_dstE  = mreg_q.dst_e;
    assign M_dstM  = mreg_q.dst_m;
    assign CC      = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver issues one E instruction per
// cycle and queues the reference result; a monitor pops and compares.
module tb_execute_stage;

    typedef struct packed {
        logic [63:0] val_e;
        logic        cnd;
        logic [3:0]  dst_e;
    } comb_exp_t;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [2:0]  cc;
    } m_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valc, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_ifun, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [2:0]  CC;

    comb_exp_t comb_q[$];
    m_exp_t    m_q[$];
    logic      m_pend = 1'b0;
    int        checks = 0;
    int        failures = 0;

    // Reference condition codes, {ZF,SF,OF}.
    logic      r_zf = 1'b1, r_sf = 1'b0, r_of = 1'b0;

    localparam logic [3:0] AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valc(E_valc), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .CC(CC)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_image(input string tag);
        chk({tag, "_M_stat"}, 64'(M_stat), 64'(AOK));
        chk({tag, "_M_icode"}, 64'(M_icode), 64'd1);
        chk({tag, "_M_ifun"}, 64'(M_ifun), 64'd0);
        chk({tag, "_M_Cnd"}, 64'(M_Cnd), 64'd0);
        chk({tag, "_M_valE"}, M_valE, 64'd0);
        chk({tag, "_M_valA"}, M_valA, 64'd0);
        chk({tag, "_M_dstE"}, 64'(M_dstE), 64'hF);
        chk({tag, "_M_dstM"}, 64'(M_dstM), 64'hF);
        chk({tag, "_CC"}, 64'(CC), 64'b100);
    endtask

    // Reference model: operand table, wide signed arithmetic for overflow.
    task automatic issue(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] valc, input logic [63:0] vala, input logic [63:0] valb,
                         input logic [3:0] dste, input logic [3:0] dstm,
                         input logic [3:0] ms, input logic [3:0] ws, input logic bub);
        logic [63:0] a, b, r;
        logic [64:0] wide;
        logic        ofl, zf, sf, cnd, lt;
        logic [3:0]  fn, de;
        comb_exp_t   ce;
        m_exp_t      me;
        @(posedge clk);
        #1;
        E_stat = stat; E_icode = icode; E_ifun = ifun; E_valc = valc;
        E_valA = vala; E_valB = valb; E_dstE = dste; E_dstM = dstm;
        m_stat = ms; W_stat = ws; M_bubble = bub;
        a = 64'd0; b = 64'd0;
        case (icode)
            4'h2: a = vala;
            4'h3: a = valc;
            4'h4, 4'h5: begin a = valc; b = valb; end
            4'h6: begin a = vala; b = valb; end
            4'h8, 4'hA: begin a = 64'd0 - 64'd8; b = valb; end
            4'h9, 4'hB: begin a = 64'd8; b = valb; end
            default: ;
        endcase
        fn = (icode == 4'h6) ? ifun : 4'h0;
        ofl = 1'b0;
        r = 64'd0;
        case (fn)
            4'h0: begin wide = {b[63], b} + {a[63], a}; r = wide[63:0]; ofl = wide[64] != wide[63]; end
            4'h1: begin wide = {b[63], b} - {a[63], a}; r = wide[63:0]; ofl = wide[64] != wide[63]; end
            4'h2: r = a & b;
            4'h3: r = a ^ b;
            default: ;
        endcase
        zf = (r == 64'd0);
        sf = r[63];
        lt = (r_sf != r_of);
        cnd = 1'b0;
        if (icode == 4'h2 || icode == 4'h7) begin
            case (ifun)
                4'h0: cnd = 1'b1;
                4'h1: cnd = lt || r_zf;
                4'h2: cnd = lt;
                4'h3: cnd = r_zf;
                4'h4: cnd = !r_zf;
                4'h5: cnd = !lt;
                4'h6: cnd = !lt && !r_zf;
                default: cnd = 1'b0;
            endcase
        end
        de = (icode == 4'h2 && !cnd) ? 4'hF : dste;
        ce = '{val_e: r, cnd: cnd, dst_e: de};
        comb_q.push_back(ce);
        if (icode == 4'h6 && ms == AOK && ws == AOK) begin
            r_zf = zf; r_sf = sf; r_of = ofl;
        end
        if (bub)
            me = '{stat: AOK, icode: 4'h1, ifun: 4'h0, cnd: 1'b0, val_e: 64'd0, val_a: 64'd0,
                   dst_e: 4'hF, dst_m: 4'hF, cc: {r_zf, r_sf, r_of}};
        else
            me = '{stat: stat, icode: icode, ifun: ifun, cnd: cnd, val_e: r, val_a: vala,
                   dst_e: de, dst_m: dstm, cc: {r_zf, r_sf, r_of}};
        m_q.push_back(me);
    endtask

    // Monitor: combinational results mid-cycle, registered results after the edge.
    initial begin
        comb_exp_t ce;
        m_exp_t    me;
        forever begin
            @(negedge clk);
            if (comb_q.size() > 0) begin
                ce = comb_q.pop_front();
                me = m_q.pop_front();
                m_pend = 1'b1;
                chk("e_valE", e_valE, ce.val_e);
                chk("e_Cnd", 64'(e_Cnd), 64'(ce.cnd));
                chk("e_dstE", 64'(e_dstE), 64'(ce.dst_e));
                @(posedge clk);
                #2;
                chk("M_stat", 64'(M_stat), 64'(me.stat));
                chk("M_icode", 64'(M_icode), 64'(me.icode));
                chk("M_ifun", 64'(M_ifun), 64'(me.ifun));
                chk("M_Cnd", 64'(M_Cnd), 64'(me.cnd));
                chk("M_valE", M_valE, me.val_e);
                chk("M_valA", M_valA, me.val_a);
                chk("M_dstE", 64'(M_dstE), 64'(me.dst_e));
                chk("M_dstM", 64'(M_dstM), 64'(me.dst_m));
                chk("CC", 64'(CC), 64'(me.cc));
                m_pend = 1'b0;
            end
        end
    end

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 7))
            0: rand_val = 64'd0;
            1: rand_val = 64'd1;
            2: rand_val = 64'h7FFF_FFFF_FFFF_FFFF;
            3: rand_val = 64'h8000_0000_0000_0000;
            4: rand_val = 64'hFFFF_FFFF_FFFF_FFFF;
            default: rand_val = {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] st, ms, ws;
        logic       bub;
        rst = 1'b1;
        E_stat = AOK; E_icode = 4'h1; E_ifun = 4'h0; E_valc = 64'd0;
        E_valA = 64'd0; E_valB = 64'd0; E_dstE = 4'hF; E_dstM = 4'hF;
        m_stat = AOK; W_stat = AOK; M_bubble = 1'b0;
        #12;
        chk_reset_image("reset");
        rst = 1'b0;

        issue(AOK, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'h2, 4'h3, 64'd0, 64'd42, 64'd0, 4'h3, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'h2, 4'h4, 64'd0, 64'd7, 64'd0, 4'h2, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'hA, 4'h0, 64'd0, 64'd9, 64'd254, 4'h4, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'hB, 4'h0, 64'd0, 64'd246, 64'd246, 4'h4, 4'h6, AOK, AOK, 1'b0);
        issue(AOK, 4'h6, 4'h3, 64'd0, 64'h0F0F, 64'h00FF, 4'h1, 4'hF, ADR, AOK, 1'b0);
        issue(HLT, 4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h1, 4'hF, ADR, HLT, 1'b0);
        issue(ADR, 4'h6, 4'h1, 64'd0, 64'd3, 64'd1, 4'h1, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'h6, 4'h0, 64'd0, 64'd9, 64'd9, 4'h2, 4'hF, ADR, AOK, 1'b1);

        for (int i = 0; i < 300; i++) begin
            st  = 4'b1000 >> $urandom_range(0, 3);
            ms  = ($urandom_range(0, 3) == 0) ? (4'b1000 >> $urandom_range(0, 3)) : AOK;
            ws  = ($urandom_range(0, 3) == 0) ? (4'b1000 >> $urandom_range(0, 3)) : AOK;
            bub = ($urandom_range(0, 9) == 0);
            if (bub) ms = ADR;
            issue(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), rand_val(),
                  rand_val(), rand_val(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ms, ws, bub);
        end

        issue(AOK, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, 4'hF, AOK, AOK, 1'b0);
        issue(AOK, 4'h3, 4'h0, 64'h1234, 64'd77, 64'd0, 4'h5, 4'h7, AOK, AOK, 1'b0);

        for (int i = 0; i < 20 && (comb_q.size() != 0 || m_pend); i++) @(posedge clk);
        if (comb_q.size() != 0 || m_pend) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", comb_q.size());
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_image("async_rst");
        @(posedge clk);
        #2;
        chk_reset_image("rst_held");
        rst = 1'b0;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline Execute (E) stage, directly downstream of decode/write-back. It consumes the E_* pipeline register produced by decode.
- Contains the ALU, the condition-code register (ZF/SF/OF) and the branch/cmov condition evaluator.
- Produces the e_dstE/e_valE forwarding signals that go back to decode, and registers the E→M pipeline register (M_*) that feeds memory.

Parameters:
- WORD, 64, datapath width of valC/valA/valB/valE.
- RNONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- E_stat  in  4  stat of the instruction in E; one-hot [0:3]: AOK=1000, HLT=0100, ADR=0010, INS=0001
- E_icode, E_ifun  in  4 each  instruction code and function
- E_valc, E_valA, E_valB  in  64 each  operands from decode
- E_dstE, E_dstM  in  4 each  destination register IDs
- m_stat  in  4  stat currently in the memory stage (combinational)
- W_stat  in  4  stat currently in write-back
- M_bubble  in  1  from pipeline control; inject a bubble into M on the next edge
- e_valE  out  64  combinational ALU result
- e_dstE  out  4  combinational effective destE, to decode forwarding
- e_Cnd  out  1  combinational condition result
- M_stat  out  4  registered
- M_icode, M_ifun  out  4 each  registered
- M_Cnd  out  1  registered
- M_valE, M_valA  out  64 each  registered
- M_dstE, M_dstM  out  4 each  registered
- CC  out  3  registered {ZF,SF,OF}, exposed for debug

Behaviour:
- Reset (async, rst=1): M_stat=1000, M_icode=1 (nop), M_ifun=0, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=F, CC={1,0,0}. All are held while rst=1.
- ALU inputs by E_icode:
  - 2 (rrmovq/cmov): aluA=valA, aluB=0
  - 3 (irmovq): aluA=valC, aluB=0
  - 4, 5 (rmmovq/mrmovq): aluA=valC, aluB=valB
  - 6 (OPq): aluA=valA, aluB=valB
  - 8, A (call/push): aluA=-8, aluB=valB
  - 9, B (ret/pop): aluA=+8, aluB=valB
  - any other icode: aluA=aluB=0
- ALU function is E_ifun when icode=6, otherwise ADD. Functions: 0 ADD = B+A, 1 SUB = B-A, 2 AND, 3 XOR. Any other ifun gives 0.
- Arithmetic is 64-bit two's complement; wrap-around is silent.
- Flags computed from the result:
  - ZF = (res==0); SF = res[63].
  - ADD OF = (A[63]==B[63]) && (res[63]!=A[63]).
  - SUB OF = (A[63]!=B[63]) && (res[63]!=B[63]).
  - AND and XOR give OF=0.
- set_cc = (E_icode==6) && m_stat==AOK && W_stat==AOK.
  - CC updates on the clock edge only when set_cc=1.
  - The new CC is visible to the instruction in E on the following cycle; the current instruction's e_Cnd uses the old CC.
- e_Cnd by E_ifun (for icode 2 and 7): 0 always=1, 1 le=(SF^OF)|ZF, 2 l=SF^OF, 3 e=ZF, 4 ne=!ZF, 5 ge=!(SF^OF), 6 g=!(SF^OF)&!ZF. Other ifun gives 0. e_Cnd=0 for all other icodes.
- e_dstE = F when (E_icode==2 && !e_Cnd), otherwise E_dstE.
- Latency: one cycle from the E_* inputs to M_*. On each posedge with rst=0:
  - M_bubble=1: M takes the reset values. CC is still updated per set_cc; pipeline control asserts M_bubble only when set_cc is already blocked.
  - otherwise: M_stat=E_stat, M_icode, M_ifun, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM.
- Bubble arriving from decode (E_icode=1, dstE=dstM=F): passes through as a nop with valE=0.
- Non-AOK E_stat passes through unchanged.
  - If E_icode=6, CC still updates, since set_cc gates only on the downstream stats.
  - An exception in m_stat or W_stat blocks CC for any E instruction.
- Reset asserted mid-operation: M and CC return immediately to reset values, regardless of clk.
- The stage has no stall input; E never stalls.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ)
  - ALU fn codes (ALUADD/SUB/AND/XOR)
  - condition fn codes
  - stat one-hot codes (SAOK, SHLT, SADR, SINS)
  - RNONE, RRSP
- One sub-module, y86_alu: combinational, (aluA, aluB, fn) -> (res, zf, sf, of).
- The CC register, condition logic and M register stay in execute_stage.

Test Plan:
- OPq add, ifun 0, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, statuses AOK.
  - e_valE=0x8000_0000_0000_0000.
  - Next cycle CC={0,1,1} and M_valE equals that value.
- OPq sub, ifun 1, valA=5, valB=5, then cmov ifun 3 (e), valA=42, dstE=3.
  - Sub: e_valE=0, CC={1,0,0}.
  - Cmov: e_Cnd=1, e_dstE=3, M_valE=42.
- Cmov ifun 4 (ne) with ZF=1, dstE=2.
  - e_dstE=F, M_dstE=F, M_Cnd=0.
- Push, icode A, valB=254: e_valE=246, M_dstE=E_dstE=4. Pop, icode B, valB=246: e_valE=254.
- OPq xor with m_stat=ADR.
  - CC unchanged and M_stat=E_stat.
  - With W_stat=HLT as well, CC stays unchanged.
- M_bubble=1 with an OPq in E: M_icode=1, M_dstE=F, M_valE=0.
- Assert rst between clock edges: M_* and CC go to reset values immediately.
